// File: rtl/fetch_pkg.sv
// fetch_pkg: shared definitions for the instruction-fetch stage.
// Holds the fetch FSM state encoding, the default reset PC and the NOP word.
package fetch_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;
  localparam logic [31:0] NOP              = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_unit_if.sv
// fetch_unit_if: instruction-memory request bus between fetch_unit and imem.
// Handshake: imem_req is the valid. While imem_req is high, imem_addr is
// stable and imem_req stays high until the cycle imem_ready is high; in that
// cycle the transfer completes and imem_rdata carries the word for imem_addr.
// imem_ready is ignored whenever imem_req is low.
interface fetch_unit_if;

  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ready,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ready,
    output imem_rdata
  );

endinterface

// File: rtl/fetch_unit_pc_reg.sv
// pc_reg_unit: architectural PC, deferred-write register and alignment logic.
// Writes arriving while a fetch request is outstanding are parked in a
// pending register and applied on the edge that leaves REQ, so the fetch
// address never moves under an open request.
// Optional feature macro: FETCH_ALIGN_CHECK_EN -- when defined, a misaligned
// load is rejected and raises a sticky misalign flag; otherwise the two low
// address bits are forced to zero on every load.
module pc_reg_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_req_i,     // FSM is in REQ
  input  logic        leave_req_i,  // FSM leaves REQ at this edge
  input  logic        pc_write_i,
  input  logic [31:0] npc_i,
  output logic [31:0] pc_o,
  output logic        misalign_o
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] pend_pc_q, pend_pc_d;
  logic        pend_valid_q, pend_valid_d;
  logic        apply;
  logic [31:0] apply_val;
`ifdef FETCH_ALIGN_CHECK_EN
  logic        mis_q, mis_d;
`endif

  // Next-state: choose which value (if any) lands in the PC this edge.
  always_comb begin
    pc_d         = pc_q;
    pend_pc_d    = pend_pc_q;
    pend_valid_d = pend_valid_q;
    apply        = 1'b0;
    apply_val    = npc_i;
`ifdef FETCH_ALIGN_CHECK_EN
    mis_d        = mis_q;
`endif
    if (in_req_i) begin
      if (pc_write_i) begin
        pend_valid_d = 1'b1;
        pend_pc_d    = npc_i;
      end
      if (leave_req_i) begin
        // A write in the exit cycle is the newest one, so it wins.
        apply        = pc_write_i | pend_valid_q;
        apply_val    = pc_write_i ? npc_i : pend_pc_q;
        pend_valid_d = 1'b0;
      end
    end else if (pc_write_i) begin
      apply     = 1'b1;
      apply_val = npc_i;
    end
    if (apply) begin
`ifdef FETCH_ALIGN_CHECK_EN
      if (apply_val[1:0] != 2'b00) mis_d = 1'b1;
      else                         pc_d  = apply_val;
`else
      pc_d = apply_val & 32'hFFFF_FFFC;
`endif
    end
  end

  // State registers with synchronous reset; reset drops any pending write.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q         <= RESET_PC;
      pend_pc_q    <= 32'h0000_0000;
      pend_valid_q <= 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
      mis_q        <= 1'b0;
`endif
    end else begin
      pc_q         <= pc_d;
      pend_pc_q    <= pend_pc_d;
      pend_valid_q <= pend_valid_d;
`ifdef FETCH_ALIGN_CHECK_EN
      mis_q        <= mis_d;
`endif
    end
  end

  assign pc_o = pc_q;
`ifdef FETCH_ALIGN_CHECK_EN
  assign misalign_o = mis_q;
`else
  assign misalign_o = 1'b0;
`endif

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: multicycle MIPS instruction-fetch stage. Owns the fetch FSM and
// the instruction register; the PC lives in pc_reg_unit. Alignment checking
// is selected by the FETCH_ALIGN_CHECK_EN macro inside pc_reg_unit.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter logic [31:0] IR_RESET = NOP
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                fetch_start,
  input  logic                pc_write,
  input  logic [31:0]         npc_in,
  fetch_unit_if.master        imem,
  output logic [31:0]         pc,
  output logic [31:0]         ir,
  output logic                fetch_done,
  output logic                busy,
  output logic                misalign,
  output fetch_state_e        dbg_state
);

  fetch_state_e state_q, state_d;
  logic [31:0]  ir_q;
  logic         leave_req;

  // Next-state logic; a latched misalign fault blocks new fetches.
  always_comb begin
    state_d   = state_q;
    leave_req = 1'b0;
    case (state_q)
      ST_IDLE: if (fetch_start && !misalign) state_d = ST_REQ;
      ST_REQ: begin
        if (imem.imem_ready) begin
          state_d   = ST_DONE;
          leave_req = 1'b1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Instruction register captures the word on the accepting cycle only.
  always_ff @(posedge clk) begin
    if (rst)                                        ir_q <= IR_RESET;
    else if (state_q == ST_REQ && imem.imem_ready)  ir_q <= imem.imem_rdata;
  end

  pc_reg_unit #(.RESET_PC(RESET_PC)) u_pc_reg (
    .clk         (clk),
    .rst         (rst),
    .in_req_i    (state_q == ST_REQ),
    .leave_req_i (leave_req),
    .pc_write_i  (pc_write),
    .npc_i       (npc_in),
    .pc_o        (pc),
    .misalign_o  (misalign)
  );

  assign imem.imem_req  = (state_q == ST_REQ);
  assign imem.imem_addr = pc;
  assign ir             = ir_q;
  assign fetch_done     = (state_q == ST_DONE);
  assign busy           = (state_q != ST_IDLE);
  assign dbg_state      = state_q;

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed self-checking bench for fetch_unit.
module tb_fetch_unit;
  import fetch_pkg::*;

  // Clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic         fetch_start;
  logic         pc_write;
  logic [31:0]  npc_in;
  logic [31:0]  pc;
  logic [31:0]  ir;
  logic         fetch_done;
  logic         busy;
  logic         misalign;
  fetch_state_e dbg_state;

  fetch_unit_if imem_bus ();

  int pass_cnt = 0;
  int total_cnt = 0;

  fetch_unit dut (
    .clk         (clk),
    .rst         (rst),
    .fetch_start (fetch_start),
    .pc_write    (pc_write),
    .npc_in      (npc_in),
    .imem        (imem_bus.master),
    .pc          (pc),
    .ir          (ir),
    .fetch_done  (fetch_done),
    .busy        (busy),
    .misalign    (misalign),
    .dbg_state   (dbg_state)
  );

  // Advance one clock; inputs change and outputs are sampled 1 time unit
  // after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; fetch_start = 1'b0; pc_write = 1'b0; npc_in = 32'h0;
    imem_bus.imem_ready = 1'b0; imem_bus.imem_rdata = 32'h0;
    tick(); tick();
    rst = 1'b0;
    total_cnt++; if (pc !== 32'h0000_3000) $display("FAIL reset_pc got=%h exp=%h", pc, 32'h0000_3000); else pass_cnt++;
    total_cnt++; if (ir !== 32'h0) $display("FAIL reset_ir got=%h exp=%h", ir, 32'h0); else pass_cnt++;
    total_cnt++; if (imem_bus.imem_req !== 1'b0) $display("FAIL reset_req got=%b exp=0", imem_bus.imem_req); else pass_cnt++;
    total_cnt++; if (fetch_done !== 1'b0) $display("FAIL reset_done got=%b exp=0", fetch_done); else pass_cnt++;
    total_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", busy); else pass_cnt++;
    total_cnt++; if (misalign !== 1'b0) $display("FAIL reset_misalign got=%b exp=0", misalign); else pass_cnt++;
  endtask

  task automatic test_single_fetch();
    fetch_start = 1'b1; imem_bus.imem_ready = 1'b1; imem_bus.imem_rdata = 32'h2408_0005;
    tick();  // cycle 1
    fetch_start = 1'b0;
    total_cnt++; if (imem_bus.imem_req !== 1'b1) $display("FAIL single_req got=%b exp=1", imem_bus.imem_req); else pass_cnt++;
    total_cnt++; if (imem_bus.imem_addr !== 32'h0000_3000) $display("FAIL single_addr got=%h exp=%h", imem_bus.imem_addr, 32'h0000_3000); else pass_cnt++;
    total_cnt++; if (busy !== 1'b1) $display("FAIL single_busy got=%b exp=1", busy); else pass_cnt++;
    total_cnt++; if (ir !== 32'h0) $display("FAIL single_ir_early got=%h exp=%h", ir, 32'h0); else pass_cnt++;
    tick();  // cycle 2
    imem_bus.imem_ready = 1'b0;
    total_cnt++; if (ir !== 32'h2408_0005) $display("FAIL single_ir got=%h exp=%h", ir, 32'h2408_0005); else pass_cnt++;
    total_cnt++; if (fetch_done !== 1'b1) $display("FAIL single_done got=%b exp=1", fetch_done); else pass_cnt++;
    total_cnt++; if (imem_bus.imem_req !== 1'b0) $display("FAIL single_req_drop got=%b exp=0", imem_bus.imem_req); else pass_cnt++;
    tick();  // back in IDLE
    total_cnt++; if (fetch_done !== 1'b0) $display("FAIL single_done_pulse got=%b exp=0", fetch_done); else pass_cnt++;
    total_cnt++; if (busy !== 1'b0) $display("FAIL single_idle_busy got=%b exp=0", busy); else pass_cnt++;
  endtask

  task automatic test_wait_states();
    imem_bus.imem_ready = 1'b0; imem_bus.imem_rdata = 32'h8C09_0000;
    fetch_start = 1'b1;
    tick();
    fetch_start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      total_cnt++; if (imem_bus.imem_req !== 1'b1) $display("FAIL wait_req[%0d] got=%b exp=1", i, imem_bus.imem_req); else pass_cnt++;
      total_cnt++; if (imem_bus.imem_addr !== 32'h0000_3000) $display("FAIL wait_addr[%0d] got=%h exp=%h", i, imem_bus.imem_addr, 32'h0000_3000); else pass_cnt++;
      total_cnt++; if (fetch_done !== 1'b0) $display("FAIL wait_done[%0d] got=%b exp=0", i, fetch_done); else pass_cnt++;
      tick();
    end
    total_cnt++; if (imem_bus.imem_req !== 1'b1) $display("FAIL wait_req_last got=%b exp=1", imem_bus.imem_req); else pass_cnt++;
    imem_bus.imem_ready = 1'b1;
    tick();
    imem_bus.imem_ready = 1'b0;
    total_cnt++; if (fetch_done !== 1'b1) $display("FAIL wait_done_final got=%b exp=1", fetch_done); else pass_cnt++;
    total_cnt++; if (ir !== 32'h8C09_0000) $display("FAIL wait_ir got=%h exp=%h", ir, 32'h8C09_0000); else pass_cnt++;
    tick();
  endtask

  task automatic test_pc_write_in_req();
    fetch_start = 1'b1;
    tick();
    fetch_start = 1'b0;
    pc_write = 1'b1; npc_in = 32'h0000_3020;
    tick();
    npc_in = 32'h0000_3010;
    tick();
    pc_write = 1'b0;
    total_cnt++; if (imem_bus.imem_addr !== 32'h0000_3000) $display("FAIL defer_addr got=%h exp=%h", imem_bus.imem_addr, 32'h0000_3000); else pass_cnt++;
    total_cnt++; if (pc !== 32'h0000_3000) $display("FAIL defer_pc_held got=%h exp=%h", pc, 32'h0000_3000); else pass_cnt++;
    imem_bus.imem_ready = 1'b1; imem_bus.imem_rdata = 32'h0000_000C;
    tick();
    imem_bus.imem_ready = 1'b0;
    total_cnt++; if (pc !== 32'h0000_3010) $display("FAIL defer_pc_applied got=%h exp=%h", pc, 32'h0000_3010); else pass_cnt++;
    total_cnt++; if (fetch_done !== 1'b1) $display("FAIL defer_done got=%b exp=1", fetch_done); else pass_cnt++;
    tick();
  endtask

  task automatic test_write_with_start();
    pc_write = 1'b1; npc_in = 32'h0000_3004; fetch_start = 1'b1;
    tick();
    pc_write = 1'b0; fetch_start = 1'b0;
    total_cnt++; if (imem_bus.imem_req !== 1'b1) $display("FAIL wstart_req got=%b exp=1", imem_bus.imem_req); else pass_cnt++;
    total_cnt++; if (imem_bus.imem_addr !== 32'h0000_3004) $display("FAIL wstart_addr got=%h exp=%h", imem_bus.imem_addr, 32'h0000_3004); else pass_cnt++;
    imem_bus.imem_ready = 1'b1; imem_bus.imem_rdata = 32'h0000_0000;
    tick();
    imem_bus.imem_ready = 1'b0;
    total_cnt++; if (pc !== 32'h0000_3004) $display("FAIL wstart_pc got=%h exp=%h", pc, 32'h0000_3004); else pass_cnt++;
    tick();
  endtask

  task automatic test_reset_mid_req();
    fetch_start = 1'b1;
    tick();
    fetch_start = 1'b0;
    pc_write = 1'b1; npc_in = 32'h0000_3100;
    tick();
    pc_write = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total_cnt++; if (imem_bus.imem_req !== 1'b0) $display("FAIL rstreq_req got=%b exp=0", imem_bus.imem_req); else pass_cnt++;
    total_cnt++; if (pc !== 32'h0000_3000) $display("FAIL rstreq_pc got=%h exp=%h", pc, 32'h0000_3000); else pass_cnt++;
    total_cnt++; if (busy !== 1'b0) $display("FAIL rstreq_busy got=%b exp=0", busy); else pass_cnt++;
    imem_bus.imem_ready = 1'b1;
    tick();
    imem_bus.imem_ready = 1'b0;
    total_cnt++; if (fetch_done !== 1'b0) $display("FAIL rstreq_done got=%b exp=0", fetch_done); else pass_cnt++;
    total_cnt++; if (pc !== 32'h0000_3000) $display("FAIL rstreq_pending got=%h exp=%h", pc, 32'h0000_3000); else pass_cnt++;
  endtask

  task automatic test_misalign();
    pc_write = 1'b1; npc_in = 32'h0000_3006;
    tick();
    pc_write = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
    total_cnt++; if (pc !== 32'h0000_3000) $display("FAIL mis_pc got=%h exp=%h", pc, 32'h0000_3000); else pass_cnt++;
    total_cnt++; if (misalign !== 1'b1) $display("FAIL mis_flag got=%b exp=1", misalign); else pass_cnt++;
    fetch_start = 1'b1;
    tick();
    fetch_start = 1'b0;
    total_cnt++; if (imem_bus.imem_req !== 1'b0) $display("FAIL mis_block got=%b exp=0", imem_bus.imem_req); else pass_cnt++;
    total_cnt++; if (misalign !== 1'b1) $display("FAIL mis_sticky got=%b exp=1", misalign); else pass_cnt++;
`else
    total_cnt++; if (pc !== 32'h0000_3004) $display("FAIL mis_pc got=%h exp=%h", pc, 32'h0000_3004); else pass_cnt++;
    total_cnt++; if (misalign !== 1'b0) $display("FAIL mis_flag got=%b exp=0", misalign); else pass_cnt++;
    fetch_start = 1'b1;
    tick();
    fetch_start = 1'b0;
    total_cnt++; if (imem_bus.imem_req !== 1'b1) $display("FAIL mis_fetch got=%b exp=1", imem_bus.imem_req); else pass_cnt++;
    total_cnt++; if (imem_bus.imem_addr !== 32'h0000_3004) $display("FAIL mis_addr got=%h exp=%h", imem_bus.imem_addr, 32'h0000_3004); else pass_cnt++;
`endif
  endtask

  initial begin
    test_reset();
    test_single_fetch();
    test_wait_states();
    test_pc_write_in_req();
    test_write_with_start();
    test_reset_mid_req();
    test_misalign();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage of the multicycle MIPS datapath, directly upstream of the next-PC logic. Owns the architectural PC register and the instruction register (IR). Fetches one word from instruction memory over a request/ready handshake when the controller asks. Loads the PC from the next-PC value when the controller commits it. Its `pc` output is the `pcin` operand of the next-PC logic; its `ir` output feeds decode and supplies the jump and branch immediates.

## Interface
Parameters:
- `RESET_PC`, default `32'h0000_3000`: PC value after reset.
- `IR_RESET`, default `32'h0000_0000` (NOP): IR value after reset.

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `fetch_start`  in  1  controller IF-state request: fetch the word at the current PC.
- `pc_write`  in  1  commit `npc_in` into the PC.
- `npc_in`  in  32  next-PC value from the next-PC logic.
- `imem_req`  out  1  instruction-memory request, held until accepted.
- `imem_addr`  out  32  fetch address, equal to the PC while `imem_req` is high.
- `imem_ready`  in  1  memory accepts the request and returns `imem_rdata` in the same cycle.
- `imem_rdata`  in  32  instruction word.
- `pc`  out  32  current PC.
- `ir`  out  32  instruction register.
- `fetch_done`  out  1  one-cycle pulse: `ir` holds the new instruction.
- `busy`  out  1  high in REQ and DONE.
- `misalign`  out  1  sticky alignment fault; see Configuration.

## Operation
- FSM states: IDLE, REQ, DONE.
  - IDLE → REQ on `fetch_start`.
  - REQ → DONE on `imem_ready`.
  - DONE → IDLE unconditionally.
- `imem_req` = (state == REQ); `imem_addr` = `pc`.
- On `imem_ready` in REQ, `ir` <= `imem_rdata`. `ir` is otherwise unchanged.
- `fetch_done` = (state == DONE); `busy` = (state != IDLE).
- `fetch_start` outside IDLE is ignored. No queuing.
- PC write:
  - In IDLE or DONE, `pc_write` loads `npc_in` at that edge.
  - In REQ, the write is deferred into a pending register, so `imem_addr` stays stable. The PC loads the pending value on the edge that leaves REQ.
  - A second `pc_write` during the same REQ overwrites the pending value; the last one wins.
- `pc_write` and `fetch_start` in the same IDLE cycle: the PC updates and REQ starts at the same edge, so the request uses the new PC.

## Timing
- Reset values: `pc`=`RESET_PC`, `ir`=`IR_RESET`, state IDLE, pending cleared, `imem_req`=0, `fetch_done`=0, `busy`=0, `misalign`=0.
- Latency with zero wait states:
  - `fetch_start` high in cycle 0.
  - `imem_req` high in cycle 1, `imem_ready` in cycle 1.
  - `ir` valid and `fetch_done` high in cycle 2.
  - Each wait cycle adds one cycle.
- `imem_ready` while not in REQ is ignored.
- Reset during REQ: `imem_req` drops in the next cycle, no `fetch_done`, and the pending write is discarded.
- PC arithmetic: full 32-bit load with no wrap logic. The PC holds exactly what the next-PC logic produced.

## Configuration
- `FETCH_ALIGN_CHECK_EN` defined:
  - A `pc_write` with `npc_in[1:0] != 0` does not update the PC and sets `misalign`.
  - `misalign` stays set until `rst`.
  - While `misalign` is set, `fetch_start` is ignored.
  - A deferred write is checked when it is applied.
- Undefined: `npc_in[1:0]` is forced to `2'b00` on every load, and `misalign` is tied to 0.

## Structure
- Shared package `fetch_pkg`: FSM state encoding, `RESET_PC` default, `NOP` constant.
- One sub-module, `pc_reg_unit`: the PC register plus the pending-write register and the alignment logic. The FSM and IR stay in `fetch_unit`.

## Test plan
- Reset, then `fetch_start` with `imem_ready`=1 and `imem_rdata`=`32'h2408_0005` → `imem_addr`=`32'h0000_3000` in cycle 1; `ir`=`32'h2408_0005` and `fetch_done` high in cycle 2.
- Three-cycle wait: `imem_ready` low for 3 REQ cycles → `imem_req`/`imem_addr` stable for 4 cycles, `fetch_done` in the 5th cycle.
- `pc_write` with `npc_in`=`32'h0000_3010` during REQ (wait state) → `imem_addr` stays `32'h0000_3000`; `pc`=`32'h0000_3010` after REQ exits.
- `pc_write` (`npc_in`=`32'h0000_3004`) together with `fetch_start` in IDLE → `imem_addr`=`32'h0000_3004`.
- `rst` asserted mid-REQ → next cycle `imem_req`=0, `pc`=`32'h0000_3000`, no `fetch_done` pulse.
- With `FETCH_ALIGN_CHECK_EN`: `pc_write` with `npc_in`=`32'h0000_3006` → `pc` unchanged, `misalign`=1, next `fetch_start` ignored. Without the macro: `pc`=`32'h0000_3004`.
